// File: rtl/video_timing_pkg.sv
// Shared timing constants, derived raster bounds and data types for the video
// timing generator and its consumers.
package video_timing_pkg;

  localparam int unsigned DEF_H_ACTIVE = 1920;
  localparam int unsigned DEF_H_FP     = 88;
  localparam int unsigned DEF_H_SYNC   = 44;
  localparam int unsigned DEF_H_BP     = 148;
  localparam int unsigned DEF_V_ACTIVE = 1080;
  localparam int unsigned DEF_V_FP     = 4;
  localparam int unsigned DEF_V_SYNC   = 5;
  localparam int unsigned DEF_V_BP     = 36;
  localparam bit          DEF_SYNC_POL = 1'b1;
  localparam int unsigned DEF_PIPE_DLY = 5;

  localparam int unsigned DEF_H_TOTAL  = DEF_H_ACTIVE + DEF_H_FP + DEF_H_SYNC + DEF_H_BP;
  localparam int unsigned DEF_V_TOTAL  = DEF_V_ACTIVE + DEF_V_FP + DEF_V_SYNC + DEF_V_BP;
  localparam int unsigned DEF_HS_START = DEF_H_ACTIVE + DEF_H_FP;
  localparam int unsigned DEF_HS_END   = DEF_HS_START + DEF_H_SYNC;
  localparam int unsigned DEF_VS_START = DEF_V_ACTIVE + DEF_V_FP;
  localparam int unsigned DEF_VS_END   = DEF_VS_START + DEF_V_SYNC;

  localparam int unsigned H_TOTAL_MAX  = 4096;
  localparam int unsigned V_TOTAL_MAX  = 2048;

  typedef logic [11:0] col_t;
  typedef logic [10:0] row_t;
  typedef logic [23:0] rgb_t;
  // One bit wider than col_t so a window end equal to H_TOTAL_MAX stays representable.
  typedef logic [12:0] win_t;

  function automatic logic in_window(input win_t v, input win_t lo, input win_t hi);
    return (v >= lo) && (v < hi);
  endfunction

endpackage

// File: rtl/video_timing_if.sv
// Raster/pixel bus between the timing generator (master) and the lookup
// stage plus display pins (slave).
interface video_timing_if;
  import video_timing_pkg::*;

  col_t display_col;
  row_t display_row;
  rgb_t color_in;
  rgb_t vga_rgb;
  logic vga_hsync;
  logic vga_vsync;
  logic vga_de;
  logic frame_start;

  modport master (
    output display_col, display_row, vga_rgb, vga_hsync, vga_vsync, vga_de, frame_start,
    input  color_in
  );

  modport slave (
    input  display_col, display_row, vga_rgb, vga_hsync, vga_vsync, vga_de, frame_start,
    output color_in
  );

endinterface

// File: rtl/video_timing_sync_delay.sv
// DEPTH-stage shift register with asynchronous reset to RST_VAL; also exposes
// the value about to enter the last stage so callers can register alongside it.
module sync_delay #(
  parameter int unsigned      DEPTH   = 5,
  parameter int unsigned      WIDTH   = 3,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clock,
  input  logic             reset,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [WIDTH-1:0] pre
);

  logic [WIDTH-1:0] stage [DEPTH];

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) stage[i] <= RST_VAL;
    end else begin
      stage[0] <= din;
      for (int i = 1; i < DEPTH; i++) stage[i] <= stage[i-1];
    end
  end

  assign dout = stage[DEPTH-1];

  if (DEPTH == 1) begin : g_pre_din
    assign pre = din;
  end else begin : g_pre_stage
    assign pre = stage[DEPTH-2];
  end

endmodule

// File: rtl/video_timing.sv
// Raster counters, sync/DE window decode, aligned sync delay line and the
// blanked pixel output register driving the video pins.
module video_timing
  import video_timing_pkg::*;
#(
  parameter int unsigned H_ACTIVE = DEF_H_ACTIVE,
  parameter int unsigned H_FP     = DEF_H_FP,
  parameter int unsigned H_SYNC   = DEF_H_SYNC,
  parameter int unsigned H_BP     = DEF_H_BP,
  parameter int unsigned V_ACTIVE = DEF_V_ACTIVE,
  parameter int unsigned V_FP     = DEF_V_FP,
  parameter int unsigned V_SYNC   = DEF_V_SYNC,
  parameter int unsigned V_BP     = DEF_V_BP,
  parameter bit          SYNC_POL = DEF_SYNC_POL,
  parameter int unsigned PIPE_DLY = DEF_PIPE_DLY
) (
  input  logic           clock,
  input  logic           reset,
  video_timing_if.master vid
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > H_TOTAL_MAX) begin : g_h_total_too_big
    $error("video_timing: H_TOTAL exceeds 4096");
  end
  if (V_TOTAL > V_TOTAL_MAX) begin : g_v_total_too_big
    $error("video_timing: V_TOTAL exceeds 2048");
  end
  if (PIPE_DLY < 1) begin : g_pipe_dly_too_small
    $error("video_timing: PIPE_DLY must be at least 1");
  end

  localparam col_t H_LAST = col_t'(H_TOTAL - 1);
  localparam row_t V_LAST = row_t'(V_TOTAL - 1);
  localparam win_t HA     = win_t'(H_ACTIVE);
  localparam win_t VA     = win_t'(V_ACTIVE);
  localparam win_t HS_LO  = win_t'(H_ACTIVE + H_FP);
  localparam win_t HS_HI  = win_t'(H_ACTIVE + H_FP + H_SYNC);
  localparam win_t VS_LO  = win_t'(V_ACTIVE + V_FP);
  localparam win_t VS_HI  = win_t'(V_ACTIVE + V_FP + V_SYNC);

  localparam logic       INACTIVE  = !SYNC_POL;
  localparam logic [2:0] IDLE_BITS = {INACTIVE, INACTIVE, 1'b0};

  col_t       col;
  row_t       row;
  logic       run;
  logic       frame_start;
  logic       de_now;
  logic       hs_now;
  logic       vs_now;
  logic [2:0] raw;
  logic [2:0] dly;
  logic [2:0] dly_pre;
  logic       pre_unused;
  rgb_t       rgb;

  // Raster counters; the first clock after reset only arms run so (0,0) is held one cycle with frame_start.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      col         <= 12'd0;
      row         <= 11'd0;
      run         <= 1'b0;
      frame_start <= 1'b0;
    end else if (!run) begin
      run         <= 1'b1;
      frame_start <= 1'b1;
    end else begin
      frame_start <= (col == H_LAST) && (row == V_LAST);
      if (col == H_LAST) begin
        col <= 12'd0;
        row <= (row == V_LAST) ? 11'd0 : row + 11'd1;
      end else begin
        col <= col + 12'd1;
      end
    end
  end

  // Window decode; syncs are converted to pin polarity before entering the delay line.
  always_comb begin
    de_now = in_window({1'b0, col}, 13'd0, HA) && in_window({2'b00, row}, 13'd0, VA);
    hs_now = in_window({1'b0, col}, HS_LO, HS_HI);
    vs_now = in_window({2'b00, row}, VS_LO, VS_HI);
    if (run) begin
      raw = {vs_now ^ INACTIVE, hs_now ^ INACTIVE, de_now};
    end else begin
      raw = IDLE_BITS;
    end
  end

  sync_delay #(
    .DEPTH   (PIPE_DLY),
    .WIDTH   (3),
    .RST_VAL (IDLE_BITS)
  ) u_sync_delay (
    .clock (clock),
    .reset (reset),
    .din   (raw),
    .dout  (dly),
    .pre   (dly_pre)
  );

  assign pre_unused = ^dly_pre[2:1];

  // Pixel register loads on the same edge as the last delay stage, gated by the DE entering it.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rgb <= 24'h000000;
    end else begin
      rgb <= dly_pre[0] ? vid.color_in : 24'h000000;
    end
  end

  assign vid.display_col = col;
  assign vid.display_row = row;
  assign vid.frame_start = frame_start;
  assign vid.vga_de      = dly[0];
  assign vid.vga_hsync   = dly[1];
  assign vid.vga_vsync   = dly[2];
  assign vid.vga_rgb     = rgb;

endmodule

// File: tb/tb_video_timing.sv
// Self-checking bench for video_timing using a reduced raster so whole frames
// fit in a short run; expected values come from hand tables and a small model.
module tb_video_timing;
  import video_timing_pkg::*;

  localparam int HA = 16, HFP = 4, HSY = 3, HBP = 5;
  localparam int VA = 6,  VFP = 2, VSY = 2, VBP = 3;
  localparam int PD = 5;
  localparam int HT = HA + HFP + HSY + HBP;   // 28
  localparam int VT = VA + VFP + VSY + VBP;   // 13
  localparam int FRAME = HT * VT;             // 364

  logic clock;
  logic reset;
  bit   lut;
  int   total;
  int   bad;
  logic [23:0] lk0, lk1, lk2, lk3;

  video_timing_if vif ();

  video_timing #(
    .H_ACTIVE (HA), .H_FP (HFP), .H_SYNC (HSY), .H_BP (HBP),
    .V_ACTIVE (VA), .V_FP (VFP), .V_SYNC (VSY), .V_BP (VBP),
    .SYNC_POL (1'b1), .PIPE_DLY (PD)
  ) dut (
    .clock (clock),
    .reset (reset),
    .vid   (vif.master)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Lookup-stage stand-in: color_in sampled at the end of cycle N+PD-1 belongs to counters of cycle N.
  always @(posedge clock) begin
    lk0 <= {1'b0, vif.display_col, vif.display_row};
    lk1 <= lk0;
    lk2 <= lk1;
    lk3 <= lk2;
  end
  assign vif.color_in = lut ? lk3 : 24'hFF00FF;

  typedef struct {
    int          t;
    logic [11:0] col;
    logic [10:0] row;
    logic        fs;
    logic        de;
    logic        hs;
    logic        vs;
    logic [23:0] rgb;
  } vec_t;

  vec_t tbl [14];

  task automatic chk(input string name, input int t, input logic [63:0] got, input logic [63:0] want);
    total++;
    if (got !== want) begin
      bad++;
      $display("FAIL %s t=%0d got=%0h want=%0h", name, t, got, want);
    end
  endtask

  task automatic step();
    @(posedge clock);
    @(negedge clock);
  endtask

  task automatic check_model(input int t);
    int c, r, s, sc, sr;
    logic de, hs, vs;
    logic [23:0] rgb;
    c = t % HT;
    r = (t / HT) % VT;
    de = 1'b0; hs = 1'b0; vs = 1'b0; rgb = 24'h0;
    if (t >= PD) begin
      s  = t - PD;
      sc = s % HT;
      sr = (s / HT) % VT;
      de = (sc < HA) && (sr < VA);
      hs = (sc >= HA + HFP) && (sc < HA + HFP + HSY);
      vs = (sr >= VA + VFP) && (sr < VA + VFP + VSY);
      if (de) rgb = lut ? {1'b0, 12'(sc), 11'(sr)} : 24'hFF00FF;
    end
    chk("counters", t, {vif.display_col, vif.display_row, vif.frame_start},
        {12'(c), 11'(r), 1'((c == 0) && (r == 0))});
    chk("syncs", t, {vif.vga_de, vif.vga_hsync, vif.vga_vsync}, {de, hs, vs});
    chk("rgb", t, vif.vga_rgb, rgb);
  endtask

  task automatic check_idle(input string name, input int t);
    chk(name, t, {vif.display_col, vif.display_row, vif.frame_start, vif.vga_de,
                  vif.vga_hsync, vif.vga_vsync, vif.vga_rgb}, 64'd0);
  endtask

  task automatic reset_and_release(input int cycles);
    reset = 1'b1;
    repeat (cycles) @(negedge clock);
    check_idle("in_reset", -1);
    reset = 1'b0;
    step();
  endtask

  initial begin
    int k, n_de, n_vs, n_fs;
    total = 0;
    bad   = 0;
    lut   = 1'b0;
    reset = 1'b1;

    //      t    col    row    fs    de    hs    vs    rgb
    tbl[0]  = '{0,   12'd0,  11'd0,  1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[1]  = '{1,   12'd1,  11'd0,  1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[2]  = '{4,   12'd4,  11'd0,  1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[3]  = '{5,   12'd5,  11'd0,  1'b0, 1'b1, 1'b0, 1'b0, 24'hFF00FF};
    tbl[4]  = '{20,  12'd20, 11'd0,  1'b0, 1'b1, 1'b0, 1'b0, 24'hFF00FF};
    tbl[5]  = '{21,  12'd21, 11'd0,  1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[6]  = '{25,  12'd25, 11'd0,  1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
    tbl[7]  = '{27,  12'd27, 11'd0,  1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
    tbl[8]  = '{28,  12'd0,  11'd1,  1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[9]  = '{33,  12'd5,  11'd1,  1'b0, 1'b1, 1'b0, 1'b0, 24'hFF00FF};
    tbl[10] = '{229, 12'd5,  11'd8,  1'b0, 1'b0, 1'b0, 1'b1, 24'h000000};
    tbl[11] = '{285, 12'd5,  11'd10, 1'b0, 1'b0, 1'b0, 1'b0, 24'h000000};
    tbl[12] = '{363, 12'd27, 11'd12, 1'b0, 1'b0, 1'b1, 1'b0, 24'h000000};
    tbl[13] = '{364, 12'd0,  11'd0,  1'b1, 1'b0, 1'b0, 1'b0, 24'h000000};

    // Two frames of constant colour: table checkpoints plus a per-cycle model check.
    reset_and_release(10);
    k = 0; n_de = 0; n_vs = 0; n_fs = 0;
    for (int t = 0; t < 2 * FRAME; t++) begin
      check_model(t);
      if (k < 14 && tbl[k].t == t) begin
        chk("table", t,
            {vif.display_col, vif.display_row, vif.frame_start, vif.vga_de,
             vif.vga_hsync, vif.vga_vsync, vif.vga_rgb},
            {tbl[k].col, tbl[k].row, tbl[k].fs, tbl[k].de, tbl[k].hs, tbl[k].vs, tbl[k].rgb});
        k++;
      end
      if (vif.vga_de) n_de++;
      if (vif.vga_vsync) n_vs++;
      if (vif.frame_start) n_fs++;
      step();
    end
    chk("table_entries", 2 * FRAME, 64'(k), 64'd14);
    chk("de_count", 2 * FRAME, 64'(n_de), 64'(2 * HA * VA));
    chk("vs_count", 2 * FRAME, 64'(n_vs), 64'(2 * VSY * HT));
    chk("fs_count", 2 * FRAME, 64'(n_fs), 64'd2);

    // Colour derived from the counters proves pixel/timing alignment.
    lut = 1'b1;
    reset_and_release(3);
    for (int t = 0; t < FRAME + 20; t++) begin
      check_model(t);
      step();
    end

    // Reset asserted between edges while hsync is active, then a clean restart.
    reset_and_release(3);
    for (int t = 0; t <= 110; t++) begin
      check_model(t);
      if (t < 110) step();
    end
    @(posedge clock);
    #2 reset = 1'b1;
    #1 check_idle("reset_async", 111);
    repeat (3) @(negedge clock);
    check_idle("reset_hold", 111);
    reset = 1'b0;
    step();
    for (int t = 0; t < 3 * HT; t++) begin
      check_model(t);
      step();
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
